// File: rtl/wbus_pkg.sv
// Shared definitions for the WBUS arbiter slice.
//   - bus arbitration mode encodings
//   - error counter width
//   - SAP-II bus source indices (position of each driver in src_en/src_data)
//   - small index wrap helper
package wbus_pkg;

  typedef enum logic {
    WBUS_MODE_PRIO = 1'b0,   // highest requesting index wins
    WBUS_MODE_RR   = 1'b1    // rotating start pointer
  } wbus_mode_e;

  localparam int ERR_COUNT_W = 8;

  // SAP-II bus driver positions
  localparam int PC  = 0;
  localparam int ACC = 1;
  localparam int MDR = 2;
  localparam int TMP = 3;
  localparam int B   = 4;
  localparam int C   = 5;
  localparam int ALU = 6;
  localparam int P1  = 7;
  localparam int P2  = 8;

  // (idx + 1) mod n for idx in [0, n-1]
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wbus_arbiter_if.sv
// WBUS source/loader bundle.
//   src_en    per-source bus request
//   src_lock  per-source lock request (only meaningful with src_en)
//   src_data  source i at [i*WIDTH +: WIDTH]
//   bus       current bus value
//   grant     one-hot grant, zero when idle
//   bus_valid any source enabled
//   contention more than one source enabled
// master: bus drivers/loaders side; slave: the arbiter.
interface wbus_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 9
);
  logic [N_SRC-1:0]       src_en;
  logic [N_SRC-1:0]       src_lock;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]       bus;
  logic [N_SRC-1:0]       grant;
  logic                   bus_valid;
  logic                   contention;

  modport master (
    output src_en, src_lock, src_data,
    input  bus, grant, bus_valid, contention
  );

  modport slave (
    input  src_en, src_lock, src_data,
    output bus, grant, bus_valid, contention
  );
endinterface

// File: rtl/wbus_rr_picker.sv
// Rotating find-first: scans req starting at index `start`, wrapping
// modulo N_SRC, and returns the first set request as one-hot and index.
//   req    in  N_SRC  request vector
//   start  in  IDX_W  first index to consider (must be < N_SRC)
//   onehot out N_SRC  selected request, zero if none
//   idx    out IDX_W  selected index, zero if none
module wbus_rr_picker #(
  parameter int N_SRC = 9,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [N_SRC-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  j;
    logic found;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(start) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!found && req[j]) begin
        found     = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbus_arbiter.sv
// Parametrised shared-bus controller for SAP-class CPUs.
// Fixed-priority or round-robin arbitration, multi-cycle locking,
// narrow-source zero-extension, idle hold and contention reporting.
//   CLK        in   system clock, rising edge
//   nCLR       in   asynchronous active-low reset
//   mode       in   0 = fixed priority, 1 = round-robin
//   clr_err    in   synchronous clear of err_sticky / err_count
//   wb         slave modport of wbus_arbiter_if (sources, bus, grant, status)
//   err_sticky out  latched contention
//   err_count  out  saturating contention-cycle count
// Build option: WBUS_ARB_ERR_COUNT_EN builds the err_count counter;
// without it err_count is tied to zero.
module wbus_arbiter
  import wbus_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               N_SRC       = 9,
  parameter int               NARROW_W    = 8,
  parameter logic [N_SRC-1:0] NARROW_MASK = 9'b1_1111_1110
) (
  input  logic                   CLK,
  input  logic                   nCLR,
  input  logic                   mode,
  input  logic                   clr_err,
  wbus_arbiter_if.slave          wb,
  output logic                   err_sticky,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam int               IDX_W       = $clog2(N_SRC);
  localparam logic [WIDTH-1:0] NARROW_BITS = {WIDTH{1'b1}} >> (WIDTH - NARROW_W);

  logic [N_SRC-1:0][WIDTH-1:0] data_m;
  logic [WIDTH-1:0]            hold_q;
  logic [IDX_W-1:0]            rr_ptr;
  logic                        locked;
  logic [IDX_W-1:0]            lock_owner;

  logic [N_SRC-1:0]            rr_oh;
  logic [IDX_W-1:0]            rr_idx;
  logic [N_SRC-1:0]            g_oh;
  logic [IDX_W-1:0]            g_idx;
  logic                        req_any;
  logic                        lock_hold;
  logic                        contention;
  logic [WIDTH-1:0]            sel_data;
  logic [IDX_W-1:0]            ptr_next;

  // Narrow sources only own the low NARROW_W bits; upper bits read as zero.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign data_m[i] = NARROW_MASK[i] ? (wb.src_data[i*WIDTH +: WIDTH] & NARROW_BITS)
                                      :  wb.src_data[i*WIDTH +: WIDTH];
  end

  wbus_rr_picker #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_rr (
    .req    (wb.src_en),
    .start  (rr_ptr),
    .onehot (rr_oh),
    .idx    (rr_idx)
  );

  assign req_any    = |wb.src_en;
  assign lock_hold  = locked && wb.src_en[lock_owner];
  assign contention = $countones(wb.src_en) > 1;

  always_comb begin
    g_oh  = '0;
    g_idx = '0;
    if (lock_hold) begin
      // an active lock overrides both modes
      g_idx             = lock_owner;
      g_oh[lock_owner]  = 1'b1;
    end else if (mode == WBUS_MODE_RR) begin
      g_oh  = rr_oh;
      g_idx = rr_idx;
    end else begin
      // ascending scan: last set bit (highest index) wins
      for (int i = 0; i < N_SRC; i++) begin
        if (wb.src_en[i]) begin
          g_oh    = '0;
          g_oh[i] = 1'b1;
          g_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign sel_data = req_any ? data_m[g_idx] : hold_q;
  assign ptr_next = IDX_W'(wrap_inc(int'(g_idx), N_SRC));

  // Combinational outputs are forced quiet while reset is asserted.
  assign wb.bus        = nCLR ? sel_data : '0;
  assign wb.grant      = nCLR ? g_oh     : '0;
  assign wb.bus_valid  = nCLR & req_any;
  assign wb.contention = contention;

  // Any grant implies src_en[g_idx], so the granted source's src_lock alone
  // decides the lock for next cycle: it covers entry, continuation and the
  // release cycle where the owner still drives but drops src_lock.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      hold_q     <= '0;
      rr_ptr     <= '0;
      locked     <= 1'b0;
      lock_owner <= '0;
    end else if (req_any) begin
      hold_q <= sel_data;
      locked <= wb.src_lock[g_idx];
      if (wb.src_lock[g_idx]) lock_owner <= g_idx;
      else                    rr_ptr     <= ptr_next;
    end else begin
      locked <= 1'b0;
    end
  end

  // clr_err wins over accumulation, but a same-cycle contention still counts.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR)            err_sticky <= 1'b0;
    else if (clr_err)     err_sticky <= contention;
    else if (contention)  err_sticky <= 1'b1;
  end

`ifdef WBUS_ARB_ERR_COUNT_EN
  logic [ERR_COUNT_W-1:0] err_cnt_q;

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR)                              err_cnt_q <= '0;
    else if (clr_err)                       err_cnt_q <= ERR_COUNT_W'(contention);
    else if (contention && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_wbus_arbiter.sv
// Directed bench for wbus_arbiter: reset, priority + narrow mask,
// round-robin with wrap, locking and release, idle hold, error count
// saturation/clear, reset mid-lock.
module tb_wbus_arbiter;
  import wbus_pkg::*;

  localparam int W = 16;
  localparam int N = 9;
`ifdef WBUS_ARB_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nCLR;
  logic       mode;
  logic       clr_err;
  logic       err_sticky;
  logic [7:0] err_count;
  int         n_vec = 0;
  int         n_bad = 0;

  wbus_arbiter_if #(.WIDTH(W), .N_SRC(N)) wb();

  wbus_arbiter #(
    .WIDTH(W), .N_SRC(N), .NARROW_W(8), .NARROW_MASK(9'b1_1111_1110)
  ) dut (
    .CLK        (CLK),
    .nCLR       (nCLR),
    .mode       (mode),
    .clr_err    (clr_err),
    .wb         (wb),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [N-1:0] en, input logic [N-1:0] lk);
    mode        = m;
    wb.src_en   = en;
    wb.src_lock = lk;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    wb.src_data[i*W +: W] = d;
  endtask

  // advance to 1 time unit past the next rising edge
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nCLR    = 1'b0;
    clr_err = 1'b0;
    wb.src_data = '0;
    for (int i = 0; i < N; i++) set_data(i, 16'hBE00 | W'(i * 16'h11));
    set_data(PC,  16'h1234);
    set_data(ALU, 16'hFFAB);
    set_data(TMP, 16'h005A);

    // reset with all sources requesting
    drive(1'b0, 9'h1FF, 9'h000);
    #4;
    chk("rst_bus",   32'(wb.bus), 32'h0);
    chk("rst_grant", 32'(wb.grant), 32'h0);
    chk("rst_valid", 32'(wb.bus_valid), 32'h0);
    chk("rst_cnt",   32'(err_count), 32'h0);
    tick;
    nCLR = 1'b1;
    drive(1'b0, 9'h000, 9'h000);
    #4;
    chk("idle0_bus",   32'(wb.bus), 32'h0);
    chk("idle0_valid", 32'(wb.bus_valid), 32'h0);
    tick;

    // fixed priority, ALU narrow vs PC wide
    drive(WBUS_MODE_PRIO, 9'h041, 9'h000);
    #4;
    chk("prio_grant", 32'(wb.grant), 32'h040);
    chk("prio_bus",   32'(wb.bus), 32'h00AB);
    chk("prio_cont",  32'(wb.contention), 32'h1);
    chk("prio_valid", 32'(wb.bus_valid), 32'h1);
    tick;                                    // rr_ptr -> 7
    drive(WBUS_MODE_PRIO, 9'h001, 9'h000);
    #4;
    chk("pc_bus",     32'(wb.bus), 32'h1234);
    chk("pc_cont",    32'(wb.contention), 32'h0);
    chk("cnt_one",    32'(err_count), CNT_EN ? 32'd1 : 32'd0);
    chk("sticky_one", 32'(err_sticky), 32'h1);
    tick;                                    // rr_ptr -> 1

    // round-robin over {B, C, ALU}
    drive(WBUS_MODE_RR, 9'h070, 9'h000);
    #4; chk("rr1_grant", 32'(wb.grant), 32'h010); chk("rr1_bus", 32'(wb.bus), 32'h0044); tick;
    #4; chk("rr2_grant", 32'(wb.grant), 32'h020); chk("rr2_bus", 32'(wb.bus), 32'h0055); tick;
    #4; chk("rr3_grant", 32'(wb.grant), 32'h040); tick;
    #4; chk("rr4_grant", 32'(wb.grant), 32'h010); tick;  // wraps 7,8,0..3 -> B; ptr 5

    // wrap past index 8
    drive(WBUS_MODE_RR, 9'h101, 9'h000);
    #4; chk("wrap_p2",  32'(wb.grant), 32'h100); chk("wrap_bus", 32'(wb.bus), 32'h0088); tick;
    #4; chk("wrap_pc",  32'(wb.grant), 32'h001); tick;   // ptr -> 1

    // MDR locks for 3 cycles while ACC requests; mode flips mid-lock
    drive(WBUS_MODE_PRIO, 9'h006, 9'h004);
    #4; chk("lock1", 32'(wb.grant), 32'h004); tick;
    drive(WBUS_MODE_RR, 9'h006, 9'h004);
    #4; chk("lock2", 32'(wb.grant), 32'h004); tick;
    #4; chk("lock3", 32'(wb.grant), 32'h004); tick;
    drive(WBUS_MODE_RR, 9'h002, 9'h000);
    #4; chk("lock_acc", 32'(wb.grant), 32'h002); tick;   // ptr -> 2

    // lock on a non-requesting source is ignored
    drive(WBUS_MODE_RR, 9'h008, 9'h002);
    #4; chk("tmp_grant", 32'(wb.grant), 32'h008); tick;  // ptr -> 4

    // release by dropping src_lock while still enabled
    drive(WBUS_MODE_PRIO, 9'h006, 9'h004);
    #4; chk("rel_take", 32'(wb.grant), 32'h004); tick;
    drive(WBUS_MODE_RR, 9'h006, 9'h000);
    #4; chk("rel_cycle", 32'(wb.grant), 32'h004); tick; // ptr -> 3
    #4; chk("rel_after", 32'(wb.grant), 32'h002); tick;

    // idle hold
    drive(WBUS_MODE_PRIO, 9'h008, 9'h000);
    #4; chk("hold_drv", 32'(wb.bus), 32'h005A); tick;
    drive(WBUS_MODE_PRIO, 9'h000, 9'h000);
    #4;
    chk("hold_bus1",  32'(wb.bus), 32'h005A);
    chk("hold_grant", 32'(wb.grant), 32'h0);
    chk("hold_valid", 32'(wb.bus_valid), 32'h0);
    tick;
    #4; chk("hold_bus2", 32'(wb.bus), 32'h005A); tick;

    // saturation then clear
    drive(WBUS_MODE_PRIO, 9'h003, 9'h000);
    for (int k = 0; k < 300; k++) tick;
    #4;
    chk("sat_cnt",    32'(err_count), CNT_EN ? 32'd255 : 32'd0);
    chk("sat_sticky", 32'(err_sticky), 32'h1);
    clr_err = 1'b1;
    tick;
    #4;
    chk("clr_cont_cnt",    32'(err_count), CNT_EN ? 32'd1 : 32'd0);
    chk("clr_cont_sticky", 32'(err_sticky), 32'h1);
    drive(WBUS_MODE_PRIO, 9'h001, 9'h000);
    tick;
    #4;
    chk("clr_cnt",    32'(err_count), 32'h0);
    chk("clr_sticky", 32'(err_sticky), 32'h0);
    clr_err = 1'b0;
    tick;

    // reset mid-lock drops the lock
    drive(WBUS_MODE_PRIO, 9'h006, 9'h004);
    #4; chk("rl_take", 32'(wb.grant), 32'h004); tick;
    nCLR = 1'b0;
    #2;
    chk("rl_grant",  32'(wb.grant), 32'h0);
    chk("rl_bus",    32'(wb.bus), 32'h0);
    chk("rl_sticky", 32'(err_sticky), 32'h0);
    #2;
    nCLR = 1'b1;
    drive(WBUS_MODE_RR, 9'h006, 9'h000);
    #2;
    chk("rl_after", 32'(wb.grant), 32'h002);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wbus_arbiter.md
# wbus_arbiter

- Parametrised shared-bus controller for SAP-class CPUs.
- Replaces the fixed, combinational, last-enable-wins WBUS multiplexer in the CPU top with a configurable N-source bus.
- Adds fixed-priority or round-robin arbitration, multi-cycle bus locking, narrow-source zero-extension, a held idle value and contention reporting.
- Sits between all bus drivers (PC, ACC, MDR, TMP, B, C, ALU, input ports) and all bus loaders.

## Interface
Parameters:
- WIDTH, 16, bus width in bits
- N_SRC, 9, number of bus sources (≥2)
- NARROW_W, 8, data width of narrow sources (≤ WIDTH)
- NARROW_MASK, 9'b1_1111_1110, bit i = 1: source i drives only NARROW_W bits, zero-extended

Ports:
- CLK  in  1  system clock, rising edge
- nCLR  in  1  asynchronous, active-low reset
- src_en  in  N_SRC  per-source bus enable (request)
- src_lock  in  N_SRC  per-source lock request, meaningful only with src_en
- src_data  in  N_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin
- clr_err  in  1  synchronous clear of err_sticky and err_count
- bus  out  WIDTH  bus value (combinational)
- grant  out  N_SRC  one-hot grant, all zero when idle
- bus_valid  out  1  |src_en
- contention  out  1  more than one src_en bit set this cycle (combinational)
- err_sticky  out  1  latched contention
- err_count  out  8  saturating contention-cycle count

## Operation
Source data:
- Source data is masked to NARROW_W LSBs when NARROW_MASK[i] = 1; upper bits are zero.

Arbitration (combinational, same cycle):
- If locked and src_en[lock_owner] = 1, grant = lock_owner, regardless of mode or other requests.
- Otherwise, with mode = 0: grant = highest-index set src_en.
- Otherwise, with mode = 1: grant = first set src_en at index ≥ rr_ptr, wrapping modulo N_SRC.

Bus value:
- bus = masked data of the granted source.
- With no grant, bus = hold_q, the last driven value. This is the idle hold.

State registers, updated at CLK rise:
- hold_q <= bus when bus_valid.
- rr_ptr: with a grant g and no lock taken or held, rr_ptr <= (g+1) mod N_SRC. Unchanged when idle or locked.
- Lock entry: if grant g and src_lock[g], then locked <= 1 and lock_owner <= g.
- Lock release: if locked and src_en[lock_owner] = 0, or src_lock[lock_owner] = 0, then locked <= 0. In the release cycle the owner still holds the grant if its src_en is high; the pointer then advances past it.

Contention is independent of lock and mode:
- contention = popcount(src_en) > 1.
- On contention, err_sticky <= 1 and err_count <= err_count+1, saturating at 255.
- clr_err clears both. If contention occurs in the same cycle, err_sticky = 1 and err_count = 1.

Boundary cases:
- mode changes mid-lock: the lock persists.
- N_SRC not a power of two: rr_ptr wraps at N_SRC-1 → 0.
- src_lock without src_en: ignored.

## Timing
- bus, grant, bus_valid and contention are purely combinational from src_en, src_data, mode and state. Zero latency, so a loader can capture at the same CLK edge that ends the enable cycle.
- Arbitration state changes take effect in the cycle after the edge.
- Reset (nCLR = 0, asynchronous) forces hold_q = 0, rr_ptr = 0, locked = 0, lock_owner = 0, err_sticky = 0, err_count = 0.
- While nCLR = 0: bus = 0, grant = 0 and bus_valid = 0, regardless of src_en.
- Reset mid-lock drops the lock immediately.

## Configuration
- WBUS_ARB_ERR_COUNT_EN defined: the 8-bit saturating err_count register exists as described.
- Undefined: err_count is tied to 0 and no counter flops are built. err_sticky and contention remain.

## Structure
- Shared package wbus_pkg holds:
  - mode encodings WBUS_MODE_PRIO = 0, WBUS_MODE_RR = 1
  - ERR_COUNT_W = 8
  - the SAP-II source index constants: PC = 0, ACC = 1, MDR = 2, TMP = 3, B = 4, C = 5, ALU = 6, P1 = 7, P2 = 8
- One sub-module: wbus_rr_picker, a combinational rotate-find-first over N_SRC with start pointer, returning one-hot and index.

## Test plan
- Reset: hold nCLR low, src_en = 9'h1FF → bus = 0, grant = 0; release, all en low → bus = 0.
- Priority with narrow mask: mode = 0, en = {ALU, PC}, PC = 16'h1234, ALU = 16'hFFAB → grant = ALU, bus = 16'h00AB, contention = 1, err_count = 1.
- Round-robin: mode = 1, en = {B, C, ALU} held 4 cycles → grants B, C, ALU, B; pointer wraps past index 8 to 0.
- Lock: MDR asserts en+lock for 3 cycles while ACC requests → MDR granted all 3, then ACC granted the cycle after MDR drops en.
- Idle hold: drive TMP = 16'h005A one cycle, then all en low → bus stays 16'h005A.
- Saturation/clear: 300 contention cycles → err_count = 255; clr_err with contention the same cycle → err_count = 1, err_sticky = 1.
